// File: rtl/cmp_pkg.sv
// Shared types and constants for the shared-comparator arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cmp_pkg;

    // Sequencer states: grant in IDLE, evaluate in COMPARE, hold result in RESPOND.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        RESPOND = 2'd2
    } cmp_state_t;

    // Result encodings, packed as {y, z}.
    localparam logic [1:0] RES_GT = 2'b10;
    localparam logic [1:0] RES_LT = 2'b01;
    localparam logic [1:0] RES_EQ = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request bit at or after ptr, wrapping at N_REQ-1.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
//
// Ports:
//   req     - request vector
//   ptr     - highest-priority index for this pick
//   gnt     - one-hot grant (all zero when no request)
//   gnt_idx - encoded winner index (0 when no request)
//   gnt_vld - at least one request present
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_idx,
    output logic             gnt_vld
);

    int unsigned idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        // Walk from the lowest-priority offset down to offset 0 so the
        // closest set bit to ptr is the last (winning) assignment.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = ID_W'(idx);
            end
        end
        gnt[gnt_idx] = gnt_vld;
    end

endmodule

// File: rtl/cmp_share_arbiter.sv
// Shares one registered unsigned comparator among N_REQ requesters, round-robin.
// Latency: grant cycle, one compare cycle, then result held in RESPOND (1 job / 3 cycles peak).
// Backpressure: rsp_ready low holds the result stable and blocks all new grants.
//
// Ports:
//   clk, reset_n         - clock, async active-low reset
//   req_valid/req_ready  - per-requester handshake; req_ready is a one-hot grant in IDLE
//   req_a, req_b         - packed operands, WIDTH bits per requester
//   rsp_valid/rsp_ready  - result handshake
//   rsp_id, rsp_y, rsp_z - owner of the result and the compare bits
//   busy                 - a job is in flight
module cmp_share_arbiter
    import cmp_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_y,
    output logic                   rsp_z,
    output logic                   busy
);

    cmp_state_t       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             y_q, z_q;

    logic [N_REQ-1:0] win_gnt;
    logic [ID_W-1:0]  win_idx;
    logic             win_vld;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (win_gnt),
        .gnt_idx (win_idx),
        .gnt_vld (win_vld)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    req_ready = win_gnt;
                    a_d       = req_a[int'(win_idx)*WIDTH +: WIDTH];
                    b_d       = req_b[int'(win_idx)*WIDTH +: WIDTH];
                    id_d      = win_idx;
                    state_d   = COMPARE;
                end
            end
            COMPARE: begin
                state_d = RESPOND;
            end
            RESPOND: begin
                if (rsp_ready) begin
                    // The requester just served drops to lowest priority.
                    ptr_d   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // No grant may be advertised while reset holds the block.
        if (!reset_n) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Shared comparator: evaluates the latched operands only in COMPARE and
    // holds its result through RESPOND.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {y_q, z_q} <= 2'b00;
        end else if (state_q == COMPARE) begin
            if (a_q > b_q) begin
                {y_q, z_q} <= RES_GT;
            end else if (a_q < b_q) begin
                {y_q, z_q} <= RES_LT;
            end else begin
                {y_q, z_q} <= RES_EQ;
            end
        end
    end

    assign rsp_valid = (state_q == RESPOND);
    assign rsp_id    = id_q;
    assign rsp_y     = y_q;
    assign rsp_z     = z_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Scoreboard bench for cmp_share_arbiter: directed scenarios then random traffic.
// Latency: expects result two cycles after the grant cycle.
// Backpressure: random and directed rsp_ready stalls.
module tb_cmp_share_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic           rsp_y;
    logic           rsp_z;
    logic           busy;

    cmp_share_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_z     (rsp_z),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int y;
        int z;
    } exp_t;

    // Reference model state (owned by the monitor).
    exp_t   sb_q[$];
    int     n_cmp = 0;
    int     n_mis = 0;
    int     m_ptr = 0;
    bit     inflight = 0;
    int     age = 0;
    bit     hold = 0;
    int     prev_id, prev_y, prev_z;
    logic [N-1:0] xfer = '0;
    int     tmo_seen = 0;
    bit     end_done = 0;

    // Stimulus-side flags (owned by the main process).
    int     tmo = 0;
    bit     end_req = 0;
    bit     rnd_mode = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor / reference model.
    always @(negedge clk) begin
        bit   exp_rv;
        int   win;
        int   a, b;
        exp_t e;
        if (tmo != tmo_seen) begin
            chk("wait_timeout", tmo, tmo_seen);
            tmo_seen = tmo;
        end
        if (end_req && !end_done) begin
            chk("sb_drained", sb_q.size(), 0);
            end_done = 1;
        end
        if (!reset_n) begin
            chk("rst_rsp_valid", int'(rsp_valid), 0);
            chk("rst_req_ready", int'(req_ready), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_rsp_id", int'(rsp_id), 0);
            chk("rst_rsp_y", int'(rsp_y), 0);
            chk("rst_rsp_z", int'(rsp_z), 0);
            sb_q.delete();
            m_ptr = 0;
            inflight = 0;
            age = 0;
            hold = 0;
            xfer = '0;
        end else begin
            exp_rv = inflight && (age >= 2);
            chk("rsp_valid", int'(rsp_valid), int'(exp_rv));
            chk("busy", int'(busy), int'(inflight));
            if (hold) begin
                chk("hold_id", int'(rsp_id), prev_id);
                chk("hold_y", int'(rsp_y), prev_y);
                chk("hold_z", int'(rsp_z), prev_z);
            end
            if (inflight) begin
                chk("no_grant_busy", int'(req_ready), 0);
            end else if (req_valid != '0) begin
                win = -1;
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
                end
                chk("grant", int'(req_ready), 1 << win);
                a = int'(req_a[win*W +: W]);
                b = int'(req_b[win*W +: W]);
                e.id = win;
                e.y  = (a >= b) ? 1 : 0;
                e.z  = (a <= b) ? 1 : 0;
                sb_q.push_back(e);
                inflight = 1;
                age = 0;
            end else begin
                chk("no_grant_idle", int'(req_ready), 0);
            end
            if (exp_rv && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_id", int'(rsp_id), e.id);
                    chk("rsp_y", int'(rsp_y), e.y);
                    chk("rsp_z", int'(rsp_z), e.z);
                    m_ptr = (e.id + 1) % N;
                end
                inflight = 0;
            end
            hold = rsp_valid && !rsp_ready;
            prev_id = int'(rsp_id);
            prev_y = int'(rsp_y);
            prev_z = int'(rsp_z);
            if (inflight) age++;
            xfer = req_valid & req_ready;
        end
    end

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[i] = 1'b1;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0: rnd_op = '0;
            1: rnd_op = '1;
            default: rnd_op = W'($urandom);
        endcase
    endfunction

    // One clock of stimulus: retire granted requests, optionally add random traffic.
    task automatic step();
        logic [W-1:0] a;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~xfer;
        if (rnd_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    a = rnd_op();
                    set_req(i, a, ($urandom_range(0, 3) == 0) ? a : rnd_op());
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || inflight || req_valid != '0) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) tmo++;
        step();
    endtask

    task automatic do_reset();
        #1 reset_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Single request.
        set_req(2, 8'h30, 8'h10);
        wait_idle();

        // All four at once from reset: served 0,1,2,3.
        do_reset();
        set_req(0, 8'h12, 8'h34);
        set_req(1, 8'h55, 8'h55);
        set_req(2, 8'h80, 8'h7F);
        set_req(3, 8'h01, 8'hFF);
        wait_idle();

        // Wrap fairness: 3 granted, then 0 and 3 pending -> 0 then 3.
        set_req(3, 8'h40, 8'h41);
        step();
        set_req(0, 8'h09, 8'h08);
        set_req(3, 8'hA0, 8'hA0);
        wait_idle();

        // Backpressure with other requests pending.
        rsp_ready = 1'b0;
        set_req(1, 8'h77, 8'h66);
        repeat (3) step();
        set_req(0, 8'h05, 8'h06);
        set_req(2, 8'hC0, 8'hC0);
        repeat (10) step();
        rsp_ready = 1'b1;
        wait_idle();

        // Boundary operands.
        set_req(0, 8'hFF, 8'h00);
        wait_idle();
        set_req(1, 8'h00, 8'h00);
        wait_idle();

        // Reset while the job sits in COMPARE, then a fresh request from 0 wins.
        set_req(2, 8'h11, 8'h22);
        step();
        do_reset();
        req_valid = '0;
        set_req(0, 8'h33, 8'h22);
        set_req(1, 8'h22, 8'h33);
        wait_idle();

        // Random traffic.
        rnd_mode = 1;
        repeat (1500) step();
        rnd_mode = 0;
        rsp_ready = 1'b1;
        wait_idle();

        end_req = 1;
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
